// File: rtl/seq_detector_fsm.sv
// seq_detector_fsm: serial pattern detector (KMP-style prefix tracker).
// Consumes one qualified bit per clock, tracks the matched-prefix length of
// PATTERN, pulses match on each detection and keeps a saturating counter.
// Optional idle timeout is enabled by defining the macro SEQ_DET_TIMEOUT_EN.
module seq_detector_fsm #(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit              OVERLAP = 1'b1,
  parameter int              CNT_W   = 8,
  parameter int              TMO_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [$clog2(PAT_W+1)-1:0] state,
  output logic [$clog2(PAT_W+1)-1:0] state_next,
  output logic             timeout
);

  localparam int SW   = $clog2(PAT_W + 1);
  localparam int EW   = SW + 1;           // entry = {match, next_state}
  localparam int NENT = 2 ** (SW + 1);    // indexed by {state, din}

  // Elaboration-time parameter sanity checks.
  if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
    $error("seq_detector_fsm: PAT_W must be in 2..16");
  end
  if (TMO_CYC < 1) begin : g_bad_tmo
    $error("seq_detector_fsm: TMO_CYC must be at least 1");
  end

  // Builds the full transition table. For prefix length k and input bit b the
  // received string is PATTERN[first k bits] followed by b; the next state is
  // the longest proper prefix of PATTERN that is a suffix of that string. On a
  // full match this is the longest border, or 0 when overlaps are disabled.
  function automatic logic [NENT*EW-1:0] build_tbl();
    logic [NENT*EW-1:0] t;
    logic [16:0]        s;
    int                 best;
    logic               ok;
    logic               hit;
    t = '0;
    s = '0;
    for (int k = 0; k < PAT_W; k++) begin
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < k; j++) s[j] = PATTERN[PAT_W-1-j];
        s[k] = b[0];
        best = 0;
        for (int l = 1; l <= k + 1; l++) begin
          if (l < PAT_W) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++) begin
              if (s[k+1-l+j] != PATTERN[PAT_W-1-j]) ok = 1'b0;
            end
            if (ok) best = l;
          end
        end
        hit = (k == PAT_W - 1) && (b[0] == PATTERN[0]);
        if (hit && !OVERLAP) best = 0;
        t[(k*2+b)*EW +: EW] = {hit, best[SW-1:0]};
      end
    end
    return t;
  endfunction

  localparam logic [NENT*EW-1:0] TBL = build_tbl();

  logic [EW-1:0] tbl_entry [NENT];

  for (genvar gi = 0; gi < NENT; gi++) begin : g_tbl
    assign tbl_entry[gi] = TBL[gi*EW +: EW];
  end

  logic [SW-1:0]    state_q, state_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [EW-1:0]    entry;

  assign entry = tbl_entry[{state_q, din}];

`ifdef SEQ_DET_TIMEOUT_EN
  localparam int IW = $clog2(TMO_CYC + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          timeout_q, timeout_d;
`endif

  // Next-state, match and counter logic.
  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
    idle_d    = idle_q;
    timeout_d = 1'b0;
`endif
    if (din_valid) begin
      {match_d, state_d} = entry;
`ifdef SEQ_DET_TIMEOUT_EN
      idle_d = '0;
`endif
    end else begin
`ifdef SEQ_DET_TIMEOUT_EN
      // Idle only counts while a partial prefix is pending.
      if (state_q != '0) begin
        if (idle_q == IW'(TMO_CYC - 1)) begin
          state_d   = '0;
          timeout_d = 1'b1;
          idle_d    = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end else begin
        idle_d = '0;
      end
`endif
    end
    if (reset) state_d = '0;

    count_d = count_q;
    if (clear_cnt) begin
      count_d = '0;
    end else if (match_d && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // State, match pulse and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

`ifdef SEQ_DET_TIMEOUT_EN
  // Idle counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign match       = match_q;
  assign match_count = count_q;
  assign state       = state_q;
  assign state_next  = state_d;

endmodule

// File: tb/tb_seq_detector_fsm.sv
// Testbench for seq_detector_fsm: two instances (OVERLAP=1 and OVERLAP=0) fed
// the same stream, checked against a history-based reference model.
module tb_seq_detector_fsm;

  localparam int PAT_W = 4;
  localparam int SW    = 3;
  localparam int CNT_W = 8;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic clear_cnt = 1'b0;

  logic             match_a, match_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic [SW-1:0]    st_a, st_b, sn_a, sn_b;
  logic             to_a, to_b;

  always #5 clk = ~clk;

  seq_detector_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8), .TMO_CYC(16)) u_ov (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .match(match_a), .match_count(cnt_a), .state(st_a), .state_next(sn_a), .timeout(to_a)
  );

  seq_detector_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8), .TMO_CYC(16)) u_no (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .match(match_b), .match_count(cnt_b), .state(st_b), .state_next(sn_b), .timeout(to_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] pat_v;

  // Reference model: index 0 = overlapping instance, 1 = non-overlapping.
  logic [31:0] m_hist [2];
  int          m_hlen [2];
  int          m_cnt  [2];
  int          m_idle [2];
  bit          m_match[2];
  bit          m_to   [2];
  int          to_seen;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Longest proper prefix of the pattern that ends the received history.
  function automatic int pref_len(input logic [31:0] h, input int hl);
    int best;
    bit ok;
    best = 0;
    for (int l = 1; l < PAT_W; l++) begin
      if (l <= hl) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) if (h[l-1-j] != pat_v[PAT_W-1-j]) ok = 1'b0;
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  task automatic step(input bit d, input bit v, input bit clr, input bit rst, input bit verbose);
    logic [31:0] nh [2];
    int nl[2], nc[2], ni[2], cur;
    bit nm[2], nt[2];
    @(negedge clk);
    din = d; din_valid = v; clear_cnt = clr; reset = rst;
    for (int i = 0; i < 2; i++) begin
      cur = pref_len(m_hist[i], m_hlen[i]);
      nh[i] = m_hist[i]; nl[i] = m_hlen[i]; nc[i] = m_cnt[i]; ni[i] = m_idle[i];
      nm[i] = 1'b0; nt[i] = 1'b0;
      if (rst) begin
        nh[i] = '0; nl[i] = 0; nc[i] = 0; ni[i] = 0;
      end else begin
        if (v) begin
          nh[i] = {m_hist[i][30:0], d};
          nl[i] = (nl[i] < 31) ? nl[i] + 1 : 31;
          nm[i] = (nl[i] >= PAT_W) && (nh[i][PAT_W-1:0] == pat_v[PAT_W-1:0]);
          if (nm[i] && i == 1) begin nh[i] = '0; nl[i] = 0; end
          ni[i] = 0;
        end else begin
`ifdef SEQ_DET_TIMEOUT_EN
          if (cur != 0) begin
            ni[i] = m_idle[i] + 1;
            if (ni[i] == TMO) begin nt[i] = 1'b1; ni[i] = 0; nh[i] = '0; nl[i] = 0; end
          end else ni[i] = 0;
`endif
        end
        if (clr) nc[i] = 0;
        else if (nm[i] && nc[i] < 255) nc[i]++;
      end
    end
    #1;
    check_val("state_next_ov", int'(sn_a), pref_len(nh[0], nl[0]));
    check_val("state_next_no", int'(sn_b), pref_len(nh[1], nl[1]));
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_hist[i] = nh[i]; m_hlen[i] = nl[i]; m_cnt[i] = nc[i]; m_idle[i] = ni[i];
      m_match[i] = nm[i]; m_to[i] = nt[i];
    end
    if (to_a) to_seen++;
    check_val("state_ov", int'(st_a), pref_len(m_hist[0], m_hlen[0]));
    check_val("state_no", int'(st_b), pref_len(m_hist[1], m_hlen[1]));
    check_val("match_ov", int'(match_a), int'(m_match[0]));
    check_val("match_no", int'(match_b), int'(m_match[1]));
    check_val("count_ov", int'(cnt_a), m_cnt[0]);
    check_val("count_no", int'(cnt_b), m_cnt[1]);
    check_val("timeout_ov", int'(to_a), int'(m_to[0]));
    check_val("timeout_no", int'(to_b), int'(m_to[1]));
    if (verbose)
      $display("t=%0t rst=%0b v=%0b d=%0b clr=%0b | ov: st=%0d m=%0b c=%0d to=%0b | no: st=%0d m=%0b c=%0d",
               $time, rst, v, d, clr, st_a, match_a, cnt_a, to_a, st_b, match_b, cnt_b);
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pat_v = 16'b1011;
    for (int i = 0; i < 2; i++) begin
      m_hist[i] = '0; m_hlen[i] = 0; m_cnt[i] = 0; m_idle[i] = 0;
      m_match[i] = 1'b0; m_to[i] = 1'b0;
    end
    to_seen = 0;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Stream 1,0,1,1,0,1,1: two overlapping matches, one without overlap.
    feed(16'b1011011, 7);
    check_val("t1_count_ov", int'(cnt_a), 2);
    check_val("t1_count_no", int'(cnt_b), 1);

    // Stream 1,0,1,0,1,1 after reset: exactly one match.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    feed(16'b101011, 6);
    check_val("t3_count_ov", int'(cnt_a), 1);

    // Reset with prefix 101 pending, then a lone 1 gives no match.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    feed(16'b101, 3);
    check_val("t5_state_before", int'(st_a), 3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    feed(16'b1, 1);
    check_val("t5_count", int'(cnt_a), 0);

    // Idle timeout behaviour after prefix 10.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    feed(16'b10, 2);
    to_seen = 0;
    for (int i = 0; i < TMO; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef SEQ_DET_TIMEOUT_EN
    check_val("t6_timeouts", to_seen, 1);
    check_val("t6_state", int'(st_a), 0);
`else
    check_val("t6_timeouts", to_seen, 0);
    check_val("t6_state", int'(st_a), 2);
`endif

    // Counter saturation: 1011 then 011 repeated gives a match every 3 bits.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    feed(16'b1011, 4);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check_val("t4_saturated", int'(cnt_a), 255);
    // Clear coinciding with a detection.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check_val("t4_clear_count", int'(cnt_a), 0);
    check_val("t4_clear_match", int'(match_a), 1);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 49) == 0), 1'b0);
    end
    // Long random idle stretch with a pending prefix.
    feed(16'b101, 3);
    for (int i = 0; i < TMO + 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
